// File: rtl/max7219_rx.sv
// ---------------------------------------------------------------------------
// max7219_rx
//
// Receive-side model of the MAX7219 serial interface. DIN, CS and CLK are
// sampled asynchronously in the CLK_IN domain, 16-bit command frames are
// decoded, and a shadow copy of the MAX7219 register file is kept so the
// display state can be observed next to a driver (loopback checking).
//
// Optional feature: define MAX7219_CODEB_EN to add the segs output, which
// applies Code-B font decoding to every digit whose decode-mode bit is set.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth on DIN/CS/CLK (must be 2 or more)
//
// Ports:
//   CLK_IN      system clock (at least 4x the serial clock)
//   RST         asynchronous active-low reset
//   DIN         serial data, MSB first
//   CS          frame select / load, active low
//   CLK         serial clock, data taken on its rising edge
//   digits      digit registers, digit n in bits [8n+7:8n] (address n+1)
//   decode      decode-mode register (address 0x9)
//   intensity   intensity register (address 0xA)
//   scan_limit  scan-limit register (address 0xB)
//   normal_op   shutdown register bit0 (address 0xC), 0 = shutdown
//   disp_test   display-test register bit0 (address 0xF)
//   wr_stb      one-cycle pulse per accepted frame
//   wr_addr     address of the last accepted frame
//   wr_data     data of the last accepted frame
//   frame_err   one-cycle pulse when a frame is rejected (too few bits)
//   segs        (MAX7219_CODEB_EN only) segment patterns {DP,A..G} per digit
// ---------------------------------------------------------------------------
module max7219_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK_IN,
    input  logic        RST,
    input  logic        DIN,
    input  logic        CS,
    input  logic        CLK,
    output logic [63:0] digits,
    output logic [7:0]  decode,
    output logic [3:0]  intensity,
    output logic [2:0]  scan_limit,
    output logic        normal_op,
    output logic        disp_test,
    output logic        wr_stb,
    output logic [3:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        frame_err
`ifdef MAX7219_CODEB_EN
    ,
    output logic [63:0] segs
`endif
);

    // Synchronizer chains; index SYNC_STAGES-1 is the stable, synchronized value.
    logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,  cs_sync_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;

    logic cs_prev_q,  cs_prev_d;
    logic clk_prev_q, clk_prev_d;

    // Registered event flags; din_ev_q holds DIN as seen at the CLK rise.
    logic cs_rise_ev_q,  cs_rise_ev_d;
    logic cs_fall_ev_q,  cs_fall_ev_d;
    logic clk_rise_ev_q, clk_rise_ev_d;
    logic din_ev_q,      din_ev_d;

    // Only the low 12 bits of the last 16 shifted bits are meaningful (the
    // top nibble of a MAX7219 frame is don't-care), so only those are kept.
    logic [11:0] frame_sr_q, frame_sr_d;
    logic [4:0]  bit_cnt_q,  bit_cnt_d;

    logic [63:0] digits_q,     digits_d;
    logic [7:0]  decode_q,     decode_d;
    logic [3:0]  intensity_q,  intensity_d;
    logic [2:0]  scan_limit_q, scan_limit_d;
    logic        normal_op_q,  normal_op_d;
    logic        disp_test_q,  disp_test_d;
    logic        wr_stb_q,     wr_stb_d;
    logic [3:0]  wr_addr_q,    wr_addr_d;
    logic [7:0]  wr_data_q,    wr_data_d;

    logic       din_s, cs_s, clk_s;
    logic       accept;
    logic [3:0] frame_addr;
    logic [7:0] frame_data;
    logic [5:0] digit_base;

    assign din_s = din_sync_q[SYNC_STAGES-1];
    assign cs_s  = cs_sync_q[SYNC_STAGES-1];
    assign clk_s = clk_sync_q[SYNC_STAGES-1];

    // Synchronizers and edge detection. A CLK rise is only an event while CS
    // is low, which also makes a coincident CS rise win over a CLK rise.
    always_comb begin
        din_sync_d    = {din_sync_q[SYNC_STAGES-2:0], DIN};
        cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0],  CS};
        clk_sync_d    = {clk_sync_q[SYNC_STAGES-2:0], CLK};
        cs_prev_d     = cs_s;
        clk_prev_d    = clk_s;
        cs_rise_ev_d  = cs_s & ~cs_prev_q;
        cs_fall_ev_d  = ~cs_s & cs_prev_q;
        clk_rise_ev_d = clk_s & ~clk_prev_q & ~cs_s;
        din_ev_d      = din_s;
    end

    // Shift register and saturating bit counter. A CS fall takes priority
    // over a simultaneous CLK rise: the counter restarts and nothing shifts.
    always_comb begin
        frame_sr_d = frame_sr_q;
        bit_cnt_d  = bit_cnt_q;
        if (cs_fall_ev_q) begin
            bit_cnt_d = '0;
        end else if (clk_rise_ev_q) begin
            frame_sr_d = {frame_sr_q[10:0], din_ev_q};
            if (bit_cnt_q != 5'd31) begin
                bit_cnt_d = bit_cnt_q + 5'd1;
            end
        end
    end

    // Latch cycle: a frame is good when at least 16 bits were clocked in.
    assign accept     = cs_rise_ev_q & bit_cnt_q[4];
    assign frame_err  = cs_rise_ev_q & ~bit_cnt_q[4];
    assign frame_addr = frame_sr_q[11:8];
    assign frame_data = frame_sr_q[7:0];
    // Addresses 1..8 map to byte offsets 0..56; the 3-bit wrap turns 8 into 7.
    assign digit_base = {3'(frame_addr[2:0] - 3'd1), 3'b000};

    // Register file update on an accepted frame.
    always_comb begin
        digits_d     = digits_q;
        decode_d     = decode_q;
        intensity_d  = intensity_q;
        scan_limit_d = scan_limit_q;
        normal_op_d  = normal_op_q;
        disp_test_d  = disp_test_q;
        wr_stb_d     = accept;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        if (accept) begin
            wr_addr_d = frame_addr;
            wr_data_d = frame_data;
            case (frame_addr)
                4'h1, 4'h2, 4'h3, 4'h4,
                4'h5, 4'h6, 4'h7, 4'h8: digits_d[digit_base +: 8] = frame_data;
                4'h9:    decode_d     = frame_data;
                4'hA:    intensity_d  = frame_data[3:0];
                4'hB:    scan_limit_d = frame_data[2:0];
                4'hC:    normal_op_d  = frame_data[0];
                4'hF:    disp_test_d  = frame_data[0];
                default: ;
            endcase
        end
    end

    // State registers. Synchronizers reset to the idle line state (CS high).
    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            din_sync_q    <= '0;
            cs_sync_q     <= '1;
            clk_sync_q    <= '0;
            cs_prev_q     <= 1'b1;
            clk_prev_q    <= 1'b0;
            cs_rise_ev_q  <= 1'b0;
            cs_fall_ev_q  <= 1'b0;
            clk_rise_ev_q <= 1'b0;
            din_ev_q      <= 1'b0;
            frame_sr_q    <= '0;
            bit_cnt_q     <= '0;
            digits_q      <= '0;
            decode_q      <= '0;
            intensity_q   <= '0;
            scan_limit_q  <= '0;
            normal_op_q   <= 1'b0;
            disp_test_q   <= 1'b0;
            wr_stb_q      <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            din_sync_q    <= din_sync_d;
            cs_sync_q     <= cs_sync_d;
            clk_sync_q    <= clk_sync_d;
            cs_prev_q     <= cs_prev_d;
            clk_prev_q    <= clk_prev_d;
            cs_rise_ev_q  <= cs_rise_ev_d;
            cs_fall_ev_q  <= cs_fall_ev_d;
            clk_rise_ev_q <= clk_rise_ev_d;
            din_ev_q      <= din_ev_d;
            frame_sr_q    <= frame_sr_d;
            bit_cnt_q     <= bit_cnt_d;
            digits_q      <= digits_d;
            decode_q      <= decode_d;
            intensity_q   <= intensity_d;
            scan_limit_q  <= scan_limit_d;
            normal_op_q   <= normal_op_d;
            disp_test_q   <= disp_test_d;
            wr_stb_q      <= wr_stb_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    assign digits     = digits_q;
    assign decode     = decode_q;
    assign intensity  = intensity_q;
    assign scan_limit = scan_limit_q;
    assign normal_op  = normal_op_q;
    assign disp_test  = disp_test_q;
    assign wr_stb     = wr_stb_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

`ifdef MAX7219_CODEB_EN
    // Code-B font, segment order {A,B,C,D,E,F,G}.
    function automatic logic [6:0] codeb_font(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'h0: pat = 7'h7E;
            4'h1: pat = 7'h30;
            4'h2: pat = 7'h6D;
            4'h3: pat = 7'h79;
            4'h4: pat = 7'h33;
            4'h5: pat = 7'h5B;
            4'h6: pat = 7'h5F;
            4'h7: pat = 7'h70;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h7B;
            4'hA: pat = 7'h01;
            4'hB: pat = 7'h4F;
            4'hC: pat = 7'h37;
            4'hD: pat = 7'h0E;
            4'hE: pat = 7'h67;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    // Per-digit segment output; bit7 of the digit register is always DP.
    always_comb begin
        segs = '0;
        for (int n = 0; n < 8; n++) begin
            if (decode_q[n]) begin
                segs[8*n +: 8] = {digits_q[8*n+7], codeb_font(digits_q[8*n +: 4])};
            end else begin
                segs[8*n +: 8] = digits_q[8*n +: 8];
            end
        end
    end
`endif

endmodule

// File: tb/tb_max7219_rx.sv
// ---------------------------------------------------------------------------
// tb_max7219_rx
//
// Bench for max7219_rx. The stimulus thread bit-bangs MAX7219 frames and
// queues the write each frame should produce; a monitor on the falling edge
// of CLK_IN pops the queue on every wr_stb / frame_err and checks the write
// and the resulting register file against a small shadow model.
// ---------------------------------------------------------------------------
module tb_max7219_rx;

    logic        CLK_IN = 1'b0;
    logic        RST    = 1'b0;
    logic        DIN    = 1'b0;
    logic        CS     = 1'b1;
    logic        CLK    = 1'b0;
    logic [63:0] digits;
    logic [7:0]  decode;
    logic [3:0]  intensity;
    logic [2:0]  scan_limit;
    logic        normal_op;
    logic        disp_test;
    logic        wr_stb;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        frame_err;
`ifdef MAX7219_CODEB_EN
    logic [63:0] segs;
`endif

    max7219_rx #(.SYNC_STAGES(2)) dut (
        .CLK_IN     (CLK_IN),
        .RST        (RST),
        .DIN        (DIN),
        .CS         (CS),
        .CLK        (CLK),
        .digits     (digits),
        .decode     (decode),
        .intensity  (intensity),
        .scan_limit (scan_limit),
        .normal_op  (normal_op),
        .disp_test  (disp_test),
        .wr_stb     (wr_stb),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_err  (frame_err)
`ifdef MAX7219_CODEB_EN
        ,
        .segs       (segs)
`endif
    );

    always #5 CLK_IN = ~CLK_IN;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  pending_err = 0;
    int  tests_run   = 0;
    int  tests_failed = 0;

    // Shadow register file, written only by the monitor.
    logic [63:0] m_digits;
    logic [7:0]  m_decode;
    logic [3:0]  m_intensity;
    logic [2:0]  m_scan_limit;
    logic        m_normal_op;
    logic        m_disp_test;
    logic        prev_stb = 1'b0;
    logic        prev_err = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK_IN);
        #1;
    endtask

    // Clocks n bits of val (MSB first) with CS low; serial clock is CLK_IN/8.
    task automatic shift_bits(input logic [31:0] val, input int n);
        CS = 1'b0;
        wait_cycles(4);
        for (int i = n - 1; i >= 0; i--) begin
            DIN = val[i];
            wait_cycles(4);
            CLK = 1'b1;
            wait_cycles(4);
            CLK = 1'b0;
        end
        wait_cycles(4);
    endtask

    // Sends a whole frame, queues its expected outcome, raises CS and waits
    // for the strobe (bounded). Optionally checks the CS-rise-to-strobe latency.
    task automatic applyStimulus(input logic [31:0] val, input int n, input bit check_lat);
        wr_t e;
        int  lat;
        shift_bits(val, n);
        if (n >= 16) begin
            e.addr = val[11:8];
            e.data = val[7:0];
            exp_q.push_back(e);
        end else begin
            pending_err++;
        end
        CS = 1'b1;
        if (n >= 16) begin
            lat = 0;
            for (int k = 1; k <= 20; k++) begin
                wait_cycles(1);
                if (wr_stb) begin
                    lat = k;
                    break;
                end
            end
            if (lat == 0) checkOutput("stb_timeout", 64'd0, 64'd1);
            else if (check_lat) checkOutput("latency", 64'(lat), 64'd4);
            wait_cycles(6);
        end else begin
            wait_cycles(10);
        end
    endtask

    function automatic void model_write(input logic [3:0] a, input logic [7:0] d);
        case (a)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8:
                m_digits[8*(int'(a)-1) +: 8] = d;
            4'h9: m_decode = d;
            4'hA: m_intensity = d[3:0];
            4'hB: m_scan_limit = d[2:0];
            4'hC: m_normal_op = d[0];
            4'hF: m_disp_test = d[0];
            default: ;
        endcase
    endfunction

    // Monitor: pops the scoreboard on each strobe and compares the register file.
    always @(negedge CLK_IN) begin
        if (!RST) begin
            m_digits = '0; m_decode = '0; m_intensity = '0;
            m_scan_limit = '0; m_normal_op = 1'b0; m_disp_test = 1'b0;
        end else begin
            if (wr_stb) begin
                checkOutput("wr_stb_width", 64'(prev_stb), 64'd0);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_wr_stb", 64'(wr_addr), 64'hFFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    checkOutput("wr_addr", 64'(wr_addr), 64'(e.addr));
                    checkOutput("wr_data", 64'(wr_data), 64'(e.data));
                    model_write(e.addr, e.data);
                    checkOutput("digits", digits, m_digits);
                    checkOutput("decode", 64'(decode), 64'(m_decode));
                    checkOutput("intensity", 64'(intensity), 64'(m_intensity));
                    checkOutput("scan_limit", 64'(scan_limit), 64'(m_scan_limit));
                    checkOutput("normal_op", 64'(normal_op), 64'(m_normal_op));
                    checkOutput("disp_test", 64'(disp_test), 64'(m_disp_test));
                end
            end
            if (frame_err) begin
                checkOutput("frame_err_width", 64'(prev_err), 64'd0);
                checkOutput("frame_err_expected", 64'(pending_err > 0), 64'd1);
                if (pending_err > 0) pending_err--;
            end
        end
        prev_stb = wr_stb;
        prev_err = frame_err;
    end

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_digits"}, digits, 64'd0);
        checkOutput({tag, "_misc"},
                    64'({decode, intensity, scan_limit, normal_op, disp_test}), 64'd0);
        checkOutput({tag, "_wr"}, 64'({wr_stb, wr_addr, wr_data, frame_err}), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] digit_frames [8];
        digit_frames = '{16'h0105, 16'h0201, 16'h0302, 16'h0403,
                         16'h0504, 16'h0605, 16'h0706, 16'h0807};

        wait_cycles(3);
        check_all_zero("reset");
        RST = 1'b1;
        wait_cycles(5);

        // Shutdown register with latency measurement.
        applyStimulus(32'h0C01, 16, 1'b1);
        checkOutput("normal_op_after_0C01", 64'(normal_op), 64'd1);

        // Digit registers, intensity and scan limit.
        foreach (digit_frames[i]) applyStimulus(32'(digit_frames[i]), 16, 1'b0);
        applyStimulus(32'h0A0F, 16, 1'b0);
        applyStimulus(32'h0B07, 16, 1'b0);
        checkOutput("digits_all", digits, 64'h0706050403020105);
        checkOutput("intensity_F", 64'(intensity), 64'hF);
        checkOutput("scan_limit_7", 64'(scan_limit), 64'd7);

        // No-op and unmapped addresses strobe without changing state.
        applyStimulus(32'h00AA, 16, 1'b0);
        applyStimulus(32'h0D55, 16, 1'b0);
        checkOutput("noop_digits", digits, 64'h0706050403020105);

        // Short frame is rejected.
        applyStimulus(32'h0A05, 12, 1'b0);
        checkOutput("short_intensity", 64'(intensity), 64'hF);
        checkOutput("short_wr_addr", 64'(wr_addr), 64'hD);
        checkOutput("short_err_consumed", 64'(pending_err), 64'd0);

        // Daisy-chained 32-bit frame: only the last 16 bits count.
        applyStimulus(32'h0C01_0A03, 32, 1'b0);
        checkOutput("daisy_intensity", 64'(intensity), 64'd3);
        checkOutput("daisy_normal_op", 64'(normal_op), 64'd1);

        // Reset in mid-frame, released with CS still low.
        shift_bits(32'hAB, 8);
        RST = 1'b0;
        wait_cycles(3);
        check_all_zero("midreset");
        RST = 1'b1;
        wait_cycles(8);
        applyStimulus(32'h0F01, 16, 1'b0);
        checkOutput("disp_test_after_reset", 64'(disp_test), 64'd1);
        checkOutput("digits_after_reset", digits, 64'd0);
        checkOutput("normal_op_after_reset", 64'(normal_op), 64'd0);

`ifdef MAX7219_CODEB_EN
        applyStimulus(32'h0901, 16, 1'b0);
        applyStimulus(32'h018A, 16, 1'b0);
        checkOutput("segs_dash_dp", 64'(segs[7:0]), 64'h81);
        applyStimulus(32'h0900, 16, 1'b0);
        checkOutput("segs_raw", 64'(segs[7:0]), 64'h8A);
`endif

        wait_cycles(5);
        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        checkOutput("no_pending_err", 64'(pending_err), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
